// File: rtl/counter_mod_updown_pkg.sv
// rtl/counter_mod_updown_pkg.sv - shared encodings for the modulo up/down counter
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH
`define CNT_DIR_UP 1'b1
`define CNT_DIR_DN 1'b0
`define CNT_MODE_WRAP 0
`define CNT_MODE_SAT 1
`endif

package counter_mod_updown_pkg;

    // One event per edge at most, so the three flags are mutually exclusive by construction.
    typedef enum logic [1:0] {
        EV_NONE,
        EV_WRAP,
        EV_SAT,
        EV_LOAD_ERR
    } cnt_event_e;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } cnt_dir_e;

    localparam int MODE_WRAP = `CNT_MODE_WRAP;
    localparam int MODE_SAT  = `CNT_MODE_SAT;

endpackage

// File: rtl/counter_defs.vh
// rtl/counter_defs.vh - direction and mode encodings for the modulo up/down counter
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH
`define CNT_DIR_UP 1'b1
`define CNT_DIR_DN 1'b0
`define CNT_MODE_WRAP 0
`define CNT_MODE_SAT 1
`endif

// File: rtl/counter_mod_updown_tff_ac.sv
// rtl/counter_mod_updown_tff_ac.sv - T flip-flop with async active-low clear and sync clear
module tff_ac (
    input  logic clock,
    input  logic clear_n,
    input  logic sclr,
    input  logic t,
    output logic q
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            q <= 1'b0;
        end else if (sclr) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/counter_mod_updown.sv
// rtl/counter_mod_updown.sv - modulo-N up/down counter with wrap/saturate and event flags
module counter_mod_updown #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             sat,
    output logic             load_err
);

    import counter_mod_updown_pkg::*;

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] toggle;
    cnt_event_e       ev;

    always_comb begin
        next_q = q;
        ev     = EV_NONE;
        if (sclr) begin
            next_q = '0;
        end else if (load) begin
            if ({1'b0, din} < MOD_EXT) begin
                next_q = din;
            end else begin
                next_q = MAX_Q;
                ev     = EV_LOAD_ERR;
            end
        end else if (en) begin
            if (up == `CNT_DIR_UP) begin
                if (q != MAX_Q) begin
                    next_q = q + 1'b1;
                end else if (SATURATE == `CNT_MODE_SAT) begin
                    ev = EV_SAT;
                end else begin
                    next_q = '0;
                    ev     = EV_WRAP;
                end
            end else begin
                if (q != '0) begin
                    next_q = q - 1'b1;
                end else if (SATURATE == `CNT_MODE_SAT) begin
                    ev = EV_SAT;
                end else begin
                    next_q = MAX_Q;
                    ev     = EV_WRAP;
                end
            end
        end
    end

    // Each bit toggles exactly where the current and next count differ.
    assign toggle = q ^ next_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_ac u_tff (
            .clock   (clock),
            .clear_n (clear_n),
            .sclr    (sclr),
            .t       (toggle[i]),
            .q       (q[i])
        );
    end

    assign tc = en & (((up == `CNT_DIR_UP) & (q == MAX_Q)) |
                      ((up == `CNT_DIR_DN) & (q == '0)));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ovf      <= 1'b0;
            sat      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            ovf      <= (ev == EV_WRAP);
            sat      <= (ev == EV_SAT);
            load_err <= (ev == EV_LOAD_ERR);
        end
    end

endmodule

// File: tb/tb_counter_mod_updown.sv
// tb/tb_counter_mod_updown.sv - directed vector bench for counter_mod_updown
module tb_counter_mod_updown;

    typedef struct {
        logic       sclr;
        logic       load;
        logic [3:0] din;
        logic       en;
        logic       up;
        logic       exp_tc;
        logic [3:0] exp_q;
        logic [2:0] exp_flags;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;

    logic       sclr = 0, load = 0, en = 0, up = 1;
    logic [3:0] din = '0;
    logic [3:0] q;
    logic       tc, ovf, sat, load_err;

    logic       s_sclr = 0, s_load = 0, s_en = 0, s_up = 1;
    logic [3:0] s_din = '0;
    logic [3:0] s_q;
    logic       s_tc, s_ovf, s_sat, s_load_err;

    logic       c_sclr = 0, c_en = 0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_ovf, hi_ovf, lo_sat, hi_sat, lo_lerr, hi_lerr;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut (
        .clock(clock), .clear_n(clear_n), .sclr(sclr), .load(load), .din(din),
        .en(en), .up(up), .q(q), .tc(tc), .ovf(ovf), .sat(sat), .load_err(load_err)
    );

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clock(clock), .clear_n(clear_n), .sclr(s_sclr), .load(s_load), .din(s_din),
        .en(s_en), .up(s_up), .q(s_q), .tc(s_tc), .ovf(s_ovf), .sat(s_sat),
        .load_err(s_load_err)
    );

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_lo (
        .clock(clock), .clear_n(clear_n), .sclr(c_sclr), .load(1'b0), .din(4'd0),
        .en(c_en), .up(1'b1), .q(lo_q), .tc(lo_tc), .ovf(lo_ovf), .sat(lo_sat),
        .load_err(lo_lerr)
    );

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_hi (
        .clock(clock), .clear_n(clear_n), .sclr(c_sclr), .load(1'b0), .din(4'd0),
        .en(lo_tc), .up(1'b1), .q(hi_q), .tc(hi_tc), .ovf(hi_ovf), .sat(hi_sat),
        .load_err(hi_lerr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic l, input int d, input logic e,
                       input logic u, input logic etc, input int eq,
                       input logic eo, input logic es, input logic el);
        vec_t v;
        v.sclr = s; v.load = l; v.din = 4'(d); v.en = e; v.up = u;
        v.exp_tc = etc; v.exp_q = 4'(eq); v.exp_flags = {eo, es, el};
        vecs.push_back(v);
    endtask

    initial begin
        // flags packed as {ovf, sat, load_err}
        for (int k = 0; k < 12; k++) add(0, 0, 0, 1, 1, k == 9, (k + 1) % 10, k == 9, 0, 0);
        add(1, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 1, 9, 1, 0, 0);
        add(0, 0, 0,  1, 0, 0, 8, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0, 7, 0, 0, 0);
        add(0, 1, 12, 0, 1, 0, 9, 0, 0, 1);
        add(0, 1, 5,  1, 1, 1, 5, 0, 0, 0);
        add(0, 1, 7,  0, 1, 0, 7, 0, 0, 0);
        add(1, 1, 3,  1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 10, 0, 1, 0, 9, 0, 0, 1);
        add(0, 1, 9,  0, 1, 0, 9, 0, 0, 0);
        add(0, 1, 15, 0, 0, 0, 9, 0, 0, 1);
        add(1, 0, 0,  1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 1, 9, 1, 0, 0);

        // reset held across clock edges with the counter enabled
        en = 1; up = 1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_q", q, 0);
        check("reset_flags", {ovf, sat, load_err}, 0);
        @(negedge clock);
        en = 0;
        clear_n = 1;

        foreach (vecs[i]) begin
            @(negedge clock);
            sclr = vecs[i].sclr; load = vecs[i].load; din = vecs[i].din;
            en = vecs[i].en; up = vecs[i].up;
            #1;
            check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_flags", i), {ovf, sat, load_err}, vecs[i].exp_flags);
        end

        // async clear between edges: flags and count drop without a clock
        @(negedge clock);
        sclr = 0; load = 1; din = 9; en = 0;
        @(negedge clock);
        load = 0; en = 1; up = 1;
        @(posedge clock);
        #1;
        check("wrap_before_clear_ovf", ovf, 1);
        @(negedge clock);
        en = 0;
        #2 clear_n = 0;
        #1;
        check("async_clear_ovf", {ovf, sat, load_err}, 0);
        clear_n = 1;
        @(negedge clock);
        load = 1; din = 4;
        @(negedge clock);
        load = 0;
        check("loaded_four", q, 4);
        #2 clear_n = 0;
        #1;
        check("async_clear_q", q, 0);
        clear_n = 1;
        en = 1; up = 1;
        @(posedge clock);
        #1;
        check("after_release_q", q, 1);
        @(negedge clock);
        en = 0;

        // saturating instance
        @(negedge clock);
        s_sclr = 1;
        @(negedge clock);
        s_sclr = 0; s_en = 1; s_up = 1;
        repeat (9) @(posedge clock);
        #1;
        check("sat_reach9_q", s_q, 9);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("sat_hold%0d_q", k), s_q, 9);
            check($sformatf("sat_hold%0d_flags", k), {s_ovf, s_sat, s_load_err}, 3'b010);
        end
        @(negedge clock);
        s_up = 0;
        @(posedge clock);
        #1;
        check("sat_down_q", s_q, 8);
        check("sat_down_flags", {s_ovf, s_sat, s_load_err}, 0);
        @(negedge clock);
        s_en = 0; s_load = 1; s_din = 0;
        @(negedge clock);
        s_load = 0; s_en = 1; s_up = 0;
        #1;
        check("sat_zero_tc", s_tc, 1);
        @(posedge clock);
        #1;
        check("sat_zero_q", s_q, 0);
        check("sat_zero_flags", {s_ovf, s_sat, s_load_err}, 3'b010);
        @(negedge clock);
        s_en = 0;

        // cascade: tens stage enabled by units terminal count
        @(negedge clock);
        c_sclr = 1;
        @(negedge clock);
        c_sclr = 0; c_en = 1;
        repeat (25) @(posedge clock);
        @(negedge clock);
        c_en = 0;
        check("cascade_hi_lo", {hi_q, lo_q}, 8'h25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
